// File: rtl/riscv_defines.sv
// ============================================================================
// riscv_defines : shared encodings for the MEM-stage load/store unit
// Revision      : 1.0
// ============================================================================
`default_nettype none

package riscv_defines;

  typedef enum logic [1:0] {
    MEM_NONE  = 2'b00,
    MEM_READ  = 2'b01,
    MEM_WRITE = 2'b10
  } memaccess_t;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'b00,
    LSU_REQ  = 2'b01,
    LSU_RESP = 2'b10,
    LSU_DONE = 2'b11
  } lsu_state_t;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;

  // funct3[1:0] encodes access size; encoding 2'b11 is treated like a word.
  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] lo);
    logic mis;
    mis = 1'b0;
    case (funct3[1:0])
      SIZE_B:  mis = 1'b0;
      SIZE_H:  mis = lo[0];
      default: mis = |lo;
    endcase
    return mis;
  endfunction

endpackage

`default_nettype wire

// File: rtl/lsu_align.sv
// ============================================================================
// lsu_align : store lane/byte-enable generation and load lane extract/extend
// Revision  : 1.0
// ============================================================================
`default_nettype none

module lsu_align
  import riscv_defines::*;
#(
  parameter int XLEN = 32
) (
  input  logic [1:0]      st_size_i,
  input  logic [1:0]      st_lo_i,
  input  logic [XLEN-1:0] st_data_i,
  output logic [3:0]      st_be_o,
  output logic [XLEN-1:0] st_wdata_o,
  input  logic [2:0]      ld_funct3_i,
  input  logic [1:0]      ld_lo_i,
  input  logic [XLEN-1:0] ld_rdata_i,
  output logic [XLEN-1:0] ld_data_o
);

  logic [XLEN-1:0] w_lane;
  logic            w_sext;

  always_comb begin
    st_be_o    = 4'b1111;
    st_wdata_o = st_data_i;
    case (st_size_i)
      SIZE_B: begin
        st_be_o    = 4'b0001 << st_lo_i;
        st_wdata_o = {4{st_data_i[7:0]}};
      end
      SIZE_H: begin
        st_be_o    = st_lo_i[1] ? 4'b1100 : 4'b0011;
        st_wdata_o = {2{st_data_i[15:0]}};
      end
      default: begin
        st_be_o    = 4'b1111;
        st_wdata_o = st_data_i;
      end
    endcase
  end

  // Bring the addressed lane down to bit 0 before extending.
  assign w_lane = ld_rdata_i >> {ld_lo_i, 3'b000};
  assign w_sext = ~ld_funct3_i[2];

  always_comb begin
    ld_data_o = ld_rdata_i;
    case (ld_funct3_i[1:0])
      SIZE_B:  ld_data_o = {{(XLEN-8){w_sext & w_lane[7]}}, w_lane[7:0]};
      SIZE_H:  ld_data_o = {{(XLEN-16){w_sext & w_lane[15]}}, w_lane[15:0]};
      default: ld_data_o = ld_rdata_i;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mem_stage_lsu.sv
// ============================================================================
// mem_stage_lsu : MEM-stage load/store unit, one bus transaction per access
// Revision      : 1.0
// ============================================================================
`default_nettype none

module mem_stage_lsu
  import riscv_defines::*;
#(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  memaccess_t        memaccess_m,
  input  logic [2:0]        funct3_m,
  input  logic [ADDR_W-1:0] addr_m,
  input  logic [XLEN-1:0]   rs2_data_m,
  input  logic              forward_mem,
  input  logic [XLEN-1:0]   result_w,
  output logic              stall_mem,
  output logic [XLEN-1:0]   load_data_m,
  output logic              misaligned_m,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [3:0]        dmem_be,
  output logic [XLEN-1:0]   dmem_wdata,
  input  logic              dmem_gnt,
  input  logic              dmem_rvalid,
  input  logic [XLEN-1:0]   dmem_rdata
);

  lsu_state_t        state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  logic [3:0]        be_q;
  logic [XLEN-1:0]   wdata_q;
  logic [XLEN-1:0]   load_q;
  logic [2:0]        funct3_q;
  logic [1:0]        lo_q;

  logic              capture;
  logic              load_en;
  logic              access;
  logic              mis;
  logic [XLEN-1:0]   st_data;
  logic [3:0]        st_be;
  logic [XLEN-1:0]   st_wdata;
  logic [XLEN-1:0]   ld_ext;

  assign access  = (memaccess_m == MEM_READ) || (memaccess_m == MEM_WRITE);
  assign mis     = is_misaligned(funct3_m, addr_m[1:0]);
  assign st_data = forward_mem ? result_w : rs2_data_m;

  lsu_align #(.XLEN(XLEN)) u_align (
    .st_size_i   (funct3_m[1:0]),
    .st_lo_i     (addr_m[1:0]),
    .st_data_i   (st_data),
    .st_be_o     (st_be),
    .st_wdata_o  (st_wdata),
    .ld_funct3_i (funct3_q),
    .ld_lo_i     (lo_q),
    .ld_rdata_i  (dmem_rdata),
    .ld_data_o   (ld_ext)
  );

  always_comb begin
    state_d      = state_q;
    capture      = 1'b0;
    load_en      = 1'b0;
    stall_mem    = 1'b0;
    misaligned_m = 1'b0;
    dmem_req     = 1'b0;
    case (state_q)
      LSU_IDLE: begin
        if (access) begin
          if (mis) begin
            misaligned_m = 1'b1;
          end else begin
            stall_mem = 1'b1;
            capture   = 1'b1;
            state_d   = LSU_REQ;
          end
        end
      end
      LSU_REQ: begin
        stall_mem = 1'b1;
        dmem_req  = 1'b1;
        if (dmem_gnt) begin
          state_d = we_q ? LSU_DONE : LSU_RESP;
        end
      end
      LSU_RESP: begin
        stall_mem = 1'b1;
        if (dmem_rvalid) begin
          load_en = 1'b1;
          state_d = LSU_DONE;
        end
      end
      LSU_DONE: begin
        // Always return to IDLE so the held instruction is not reissued.
        state_d = LSU_IDLE;
      end
      default: state_d = LSU_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= LSU_IDLE;
      addr_q   <= '0;
      we_q     <= 1'b0;
      be_q     <= '0;
      wdata_q  <= '0;
      funct3_q <= '0;
      lo_q     <= '0;
      load_q   <= '0;
    end else begin
      state_q <= state_d;
      if (capture) begin
        addr_q   <= {addr_m[ADDR_W-1:2], 2'b00};
        we_q     <= (memaccess_m == MEM_WRITE);
        be_q     <= st_be;
        wdata_q  <= st_wdata;
        funct3_q <= funct3_m;
        lo_q     <= addr_m[1:0];
      end
      if (load_en) begin
        load_q <= ld_ext;
      end
    end
  end

  assign dmem_we     = we_q;
  assign dmem_addr   = addr_q;
  assign dmem_be     = be_q;
  assign dmem_wdata  = wdata_q;
  assign load_data_m = load_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_stage_lsu.sv
// ============================================================================
// tb_mem_stage_lsu : directed + randomized bench with a per-transaction model
// Revision         : 1.0
// ============================================================================
`default_nettype none

module tb_mem_stage_lsu;
  import riscv_defines::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  memaccess_t  memaccess_m;
  logic [2:0]  funct3_m;
  logic [31:0] addr_m, rs2_data_m, result_w;
  logic        forward_mem;
  logic        stall_mem, misaligned_m;
  logic [31:0] load_data_m;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_gnt, dmem_rvalid;
  logic [31:0] dmem_rdata;

  always #5 clk = ~clk;

  mem_stage_lsu #(.XLEN(32), .ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .memaccess_m(memaccess_m), .funct3_m(funct3_m),
    .addr_m(addr_m), .rs2_data_m(rs2_data_m), .forward_mem(forward_mem),
    .result_w(result_w), .stall_mem(stall_mem), .load_data_m(load_data_m),
    .misaligned_m(misaligned_m), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
    .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  // Expected outputs for the current cycle, set by the driver.
  logic        chk_en = 1'b0;
  logic        e_stall, e_req, e_mis, e_we;
  logic [31:0] e_addr, e_wdata, e_ld;
  logic [3:0]  e_be;

  always @(negedge clk) begin
    if (chk_en) begin
      chk("stall_mem", 32'(stall_mem), 32'(e_stall));
      chk("dmem_req", 32'(dmem_req), 32'(e_req));
      chk("misaligned_m", 32'(misaligned_m), 32'(e_mis));
      chk("load_data_m", load_data_m, e_ld);
      if (e_req) begin
        chk("dmem_we", 32'(dmem_we), 32'(e_we));
        chk("dmem_addr", dmem_addr, e_addr);
        chk("dmem_be", 32'(dmem_be), 32'(e_be));
        if (e_we) chk("dmem_wdata", dmem_wdata, e_wdata);
      end
    end
  end

  function automatic logic m_mis(input logic [2:0] f3, input logic [31:0] a);
    int sz;
    sz = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    return (a % sz) != 0;
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
    int sz;
    int mask;
    sz   = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    mask = ((1 << sz) - 1) << (a % 4);
    return 4'(mask);
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] d);
    if (f3[1:0] == 2'd0) return (d % 256) * 32'h0101_0101;
    if (f3[1:0] == 2'd1) return (d % 65536) * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a,
                                         input logic [31:0] rd);
    longint v;
    longint bits;
    bits = (f3[1:0] == 2'd0) ? 8 : (f3[1:0] == 2'd1) ? 16 : 32;
    v    = (longint'(rd) / (longint'(1) << (8 * (a % 4)))) % (longint'(1) << bits);
    if (!f3[2] && bits < 32 && v >= (longint'(1) << (bits - 1)))
      v = v + (longint'(1) << 32) - (longint'(1) << bits);
    return 32'(v);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycle();
    memaccess_m = MEM_NONE;
    dmem_gnt    = 1'b0;
    dmem_rvalid = 1'($urandom % 2);
    dmem_rdata  = $urandom;
    e_stall = 1'b0; e_req = 1'b0; e_mis = 1'b0;
    tick();
    dmem_rvalid = 1'b0;
  endtask

  // g = REQ cycles with gnt low before the gnt cycle; L = cycles from gnt to rvalid.
  task automatic run_txn(input memaccess_t acc, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] rs2, input logic fwd, input logic [31:0] resw,
                         input int g, input int lat, input logic [31:0] rd,
                         input logic xmis, input logic [31:0] xaddr, input logic [3:0] xbe,
                         input logic [31:0] xwd, input logic [31:0] xld);
    memaccess_m = acc; funct3_m = f3; addr_m = addr; rs2_data_m = rs2;
    forward_mem = fwd; result_w = resw;
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
    e_mis = xmis; e_stall = !xmis; e_req = 1'b0;
    tick();
    if (xmis) return;
    e_mis = 1'b0;
    for (int k = 0; k <= g; k++) begin
      e_req = 1'b1; e_stall = 1'b1; e_we = (acc == MEM_WRITE);
      e_addr = xaddr; e_be = xbe; e_wdata = xwd;
      dmem_gnt    = (k == g);
      result_w    = $urandom;
      forward_mem = 1'($urandom % 2);
      tick();
    end
    dmem_gnt = 1'b0;
    e_req    = 1'b0;
    if (acc == MEM_READ) begin
      for (int j = 1; j <= lat; j++) begin
        dmem_rvalid = (j == lat);
        dmem_rdata  = (j == lat) ? rd : $urandom;
        tick();
      end
      e_ld = xld;
    end
    e_stall     = 1'b0;
    dmem_rvalid = 1'($urandom % 2);
    dmem_rdata  = $urandom;
    tick();
    dmem_rvalid = 1'b0;
  endtask

  task automatic rand_txn();
    memaccess_t  acc;
    logic [2:0]  f3;
    logic [31:0] a, rs2, resw, rd, sd;
    logic        fwd;
    int          pick;
    acc  = ($urandom % 2) ? MEM_READ : MEM_WRITE;
    pick = int'($urandom % 5);
    if (acc == MEM_READ) f3 = (pick == 0) ? F3_LB : (pick == 1) ? F3_LH : (pick == 2) ? F3_LW :
                              (pick == 3) ? F3_LBU : F3_LHU;
    else                 f3 = (pick < 2) ? F3_SB : (pick < 4) ? F3_SH : F3_SW;
    a    = $urandom;
    rs2  = $urandom;
    resw = $urandom;
    rd   = $urandom;
    fwd  = 1'($urandom % 2);
    sd   = fwd ? resw : rs2;
    run_txn(acc, f3, a, rs2, fwd, resw, int'($urandom % 4), 1 + int'($urandom % 3), rd,
            m_mis(f3, a), a - (a % 4), m_be(f3, a), m_wdata(f3, sd), m_load(f3, a, rd));
  endtask

  initial begin
    memaccess_m = MEM_NONE; funct3_m = '0; addr_m = '0; rs2_data_m = '0;
    forward_mem = 1'b0; result_w = '0; dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
    e_stall = 1'b0; e_req = 1'b0; e_mis = 1'b0; e_we = 1'b0;
    e_addr = '0; e_wdata = '0; e_ld = '0; e_be = '0;

    #12;
    chk("reset dmem_req", 32'(dmem_req), 32'd0);
    chk("reset dmem_we", 32'(dmem_we), 32'd0);
    chk("reset dmem_addr", dmem_addr, 32'd0);
    chk("reset dmem_be", 32'(dmem_be), 32'd0);
    chk("reset dmem_wdata", dmem_wdata, 32'd0);
    chk("reset load_data_m", load_data_m, 32'd0);
    chk("reset stall_mem", 32'(stall_mem), 32'd0);
    tick();
    rst_n  = 1'b1;
    chk_en = 1'b1;
    idle_cycle();

    run_txn(MEM_WRITE, F3_SW, 32'h100, 32'hDEADBEEF, 1'b0, 32'h0, 0, 0, 32'h0,
            1'b0, 32'h100, 4'b1111, 32'hDEADBEEF, 32'h0);
    run_txn(MEM_WRITE, F3_SB, 32'h103, 32'h11111111, 1'b1, 32'h000000A5, 1, 0, 32'h0,
            1'b0, 32'h100, 4'b1000, 32'hA5A5A5A5, 32'h0);
    run_txn(MEM_READ, F3_LB, 32'h102, 32'h0, 1'b0, 32'h0, 0, 2, 32'h00800000,
            1'b0, 32'h100, 4'b0100, 32'h0, 32'hFFFFFF80);
    run_txn(MEM_READ, F3_LBU, 32'h102, 32'h0, 1'b0, 32'h0, 0, 2, 32'h00800000,
            1'b0, 32'h100, 4'b0100, 32'h0, 32'h00000080);
    run_txn(MEM_READ, F3_LH, 32'h101, 32'h0, 1'b0, 32'h0, 0, 1, 32'h0,
            1'b1, 32'h0, 4'b0, 32'h0, 32'h0);
    idle_cycle();
    run_txn(MEM_WRITE, F3_SH, 32'h20E, 32'hCAFEF00D, 1'b0, 32'h0, 5, 0, 32'h0,
            1'b0, 32'h20C, 4'b1100, 32'hF00DF00D, 32'h0);
    run_txn(MEM_READ, F3_LH, 32'h2, 32'h0, 1'b0, 32'h0, 5, 1, 32'h8001_7FFF,
            1'b0, 32'h0, 4'b1100, 32'h0, 32'hFFFF8001);

    // Reset while a load waits for its response.
    memaccess_m = MEM_READ; funct3_m = F3_LW; addr_m = 32'h300;
    e_stall = 1'b1; e_req = 1'b0; e_mis = 1'b0;
    tick();
    e_req = 1'b1; e_we = 1'b0; e_addr = 32'h300; e_be = 4'b1111;
    dmem_gnt = 1'b1;
    tick();
    dmem_gnt = 1'b0; e_req = 1'b0;
    #2;
    rst_n = 1'b0;
    memaccess_m = MEM_NONE;
    e_stall = 1'b0; e_ld = 32'h0;
    #1;
    chk("async reset dmem_req", 32'(dmem_req), 32'd0);
    chk("async reset stall_mem", 32'(stall_mem), 32'd0);
    chk("async reset load_data_m", load_data_m, 32'd0);
    dmem_rvalid = 1'b1; dmem_rdata = 32'hBADBAD00;
    tick();
    rst_n = 1'b1;
    tick();
    dmem_rvalid = 1'b0;
    tick();
    run_txn(MEM_READ, F3_LW, 32'h200, 32'h0, 1'b0, 32'h0, 0, 1, 32'h12345678,
            1'b0, 32'h200, 4'b1111, 32'h0, 32'h12345678);

    for (int i = 0; i < 300; i++) begin
      if ($urandom % 5 == 0) idle_cycle();
      rand_txn();
    end
    idle_cycle();
    chk_en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
Load/store unit in the MEM stage; consumes forward_mem from the store-data forwarding logic to pick store data, then issues one data-bus transaction per memory instruction. Aligns store data and byte enables, extends load data, and stalls the pipeline until the bus transaction completes. Sits between EX/MEM pipeline register and MEM/WB pipeline register; owns the data-memory port.

Parameters:
XLEN, 32, datapath width; only 32 supported
ADDR_W, 32, data-bus address width

Ports:
clk  in  1  core clock
rst_n  in  1  reset; asynchronous, active-low
memaccess_m  in  memaccess_t  MEM stage access kind (MEM_READ / MEM_WRITE / none)
funct3_m  in  3  RV32I load/store size and sign (LB/LH/LW/LBU/LHU, SB/SH/SW)
addr_m  in  ADDR_W  effective address (ALU result)
rs2_data_m  in  XLEN  store data from the EX/MEM register
forward_mem  in  1  select result_w as store data
result_w  in  XLEN  WB-stage result value
stall_mem  out  1  hold IF..MEM and bubble WB
load_data_m  out  XLEN  extended load result; valid in DONE
misaligned_m  out  1  access-fault flag for current instruction
dmem_req  out  1  bus request
dmem_we  out  1  1 = write
dmem_addr  out  ADDR_W  word-aligned address (addr[1:0]=0)
dmem_be  out  4  byte enables
dmem_wdata  out  XLEN  lane-aligned store data
dmem_gnt  in  1  request accepted this cycle
dmem_rvalid  in  1  read data valid
dmem_rdata  in  XLEN  read data word

Behaviour:
- States: IDLE, REQ, RESP, DONE. Reset -> IDLE; all registered outputs 0; load_data_m = 0.
- Misaligned: half with addr[0]=1, word with addr[1:0]!=0. In IDLE, misaligned_m = 1 combinationally, no request, no stall, stay IDLE. misaligned_m is 0 in all other states.
- IDLE, aligned access present: stall_mem = 1 combinationally; register addr (word-aligned), we, be, aligned wdata, funct3, addr[1:0]; next REQ.
- Store-data select at capture: forward_mem ? result_w : rs2_data_m. Captured value is used for the whole transaction; later changes of forward_mem/result_w are ignored.
- Alignment: SB -> be = 1<<addr[1:0], byte replicated on all lanes; SH -> be = 0011 or 1100, half replicated; SW -> 1111. Loads drive the same be pattern.
- REQ: dmem_req = 1, addr/we/be/wdata stable until dmem_gnt. On gnt: store -> DONE; load -> RESP.
- RESP: dmem_req = 0; wait dmem_rvalid; on rvalid extract lane by captured addr[1:0]; sign-extend (LB/LH) or zero-extend (LBU/LHU/LW) into load_data_m; next DONE. rvalid arriving in the same cycle as gnt is not legal; the bus guarantees at least 1 cycle of latency.
- DONE: stall_mem = 0; load_data_m held; pipeline advances; next IDLE unconditionally, so the same instruction is never reissued.
- stall_mem = 1 in REQ and RESP. Minimum stall: store 2 cycles, load 3 cycles.
- dmem_rvalid outside RESP is ignored.
- Reset mid-transaction: immediate return to IDLE; dmem_req drops asynchronously; any outstanding bus response is ignored.

Decomposition:
- riscv_defines: memaccess_t (existing), lsu_state_t enum, funct3 load/store encodings.
- Sub-module lsu_align: combinational store lane/be generation plus load extract/extend. Shared by both paths; FSM stays in mem_stage_lsu.

Test Plan:
- SW x, addr 0x100, rs2=0xDEADBEEF, forward_mem=0, gnt on first REQ cycle -> dmem_addr 0x100, be 1111, wdata 0xDEADBEEF, stall high exactly 2 cycles.
- SB, addr 0x103, forward_mem=1, result_w=0x000000A5, rs2=0x11111111 -> be 1000, wdata 0xA5A5A5A5; change result_w after capture -> wdata unchanged.
- LB addr 0x102, rdata 0x00800000, rvalid 2 cycles after gnt -> load_data_m 0xFFFFFF80; LBU same -> 0x00000080; stall 4 cycles.
- LH addr 0x101 -> misaligned_m=1, dmem_req never asserted, stall_mem=0.
- gnt held low 5 cycles in REQ -> req/addr/be/wdata stable all 5 cycles, stall held; then completes normally.
- rst_n low while in RESP -> dmem_req=0, state IDLE; late rvalid ignored; next LW addr 0x200, rdata 0x12345678 -> load_data_m 0x12345678.
